// File: rtl/multdiv_pkg.sv
// Shared state encoding, width and magnitude helper for mult_div_unit.
// Optional unsigned support is selected by MULTDIV_UNSIGNED_EN (see mult_div_unit).
package multdiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} md_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [MD_WIDTH-1:0] abs_w(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the control unit (master) and mult_div_unit (slave).
// MULTDIV_UNSIGNED_EN adds the unsigned_op qualifier.
interface mult_div_unit_if #(parameter int WIDTH = multdiv_pkg::MD_WIDTH);

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULTDIV_UNSIGNED_EN
  logic             unsigned_op;

  modport master (output start_mult, start_div, a, b, unsigned_op,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start_mult, start_div, a, b, unsigned_op,
                  output busy, done, div_zero, hi, lo);
`else
  modport master (output start_mult, start_div, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start_mult, start_div, a, b,
                  output busy, done, div_zero, hi, lo);
`endif

endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    // A set top bit already exceeds any divisor; otherwise diff[WIDTH] is the borrow.
    ge      = shifted[WIDTH] | ~diff[WIDTH];
    rem_o   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring + sign fix) unit producing HI/LO.
// Define MULTDIV_UNSIGNED_EN to add unsigned_op (MULTU/DIVU); default build is signed only.
//
// state | meaning
// IDLE  | waiting for a start strobe
// MULT  | WIDTH Booth iterations
// DIV   | WIDTH restoring iterations on magnitudes
// FIX   | quotient/remainder sign correction, loads HI/LO
// DONE  | one-cycle completion pulse
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_unit_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state_q, state_d;
  logic [WIDTH:0]   acc_q, m_q, booth_sum, booth_acc;
  logic [WIDTH-1:0] q_q, booth_q, hi_q, lo_q, rem_nx, quo_nx;
  logic [CW-1:0]    cnt_q;
  logic             q1_q, ucorr_q, qsign_q, rsign_q, div_zero_q;
  logic             uns, last_step;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns = io.unsigned_op;
`else
  assign uns = 1'b0;
`endif

  assign last_step = (cnt_q == CW'(1));

  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
  end

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .quo_i     (q_q),
    .divisor_i (m_q[WIDTH-1:0]),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      m_q        <= '0;
      q_q        <= '0;
      q1_q       <= 1'b0;
      cnt_q      <= '0;
      ucorr_q    <= 1'b0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (io.start_mult) begin
            acc_q      <= '0;
            q_q        <= io.b;
            q1_q       <= 1'b0;
            m_q        <= {~uns & io.a[WIDTH-1], io.a};
            cnt_q      <= CW'(WIDTH);
            // Unsigned multiplier with MSB set needs one more +M<<WIDTH to undo the signed read of b.
            ucorr_q    <= uns & io.b[WIDTH-1];
            div_zero_q <= 1'b0;
          end else if (io.start_div) begin
            if (io.b == '0) begin
              div_zero_q <= 1'b1;
            end else begin
              acc_q      <= '0;
              q_q        <= uns ? io.a : abs_w(io.a);
              m_q        <= {1'b0, (uns ? io.b : abs_w(io.b))};
              cnt_q      <= CW'(WIDTH);
              qsign_q    <= ~uns & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
              rsign_q    <= ~uns & io.a[WIDTH-1];
              div_zero_q <= 1'b0;
            end
          end
        end
        MULT: begin
          acc_q <= booth_acc;
          q_q   <= booth_q;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            hi_q <= booth_acc[WIDTH-1:0] + (ucorr_q ? m_q[WIDTH-1:0] : '0);
            lo_q <= booth_q;
          end
        end
        DIV: begin
          acc_q <= {1'b0, rem_nx};
          q_q   <= quo_nx;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          hi_q <= rsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          lo_q <= qsign_q ? -q_q : q_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (io.start_mult)     state_d = MULT;
        else if (io.start_div) state_d = (io.b == '0) ? DONE : DIV;
      end
      MULT:    if (last_step) state_d = DONE;
      DIV:     if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy = 1'b0;
    io.done = 1'b0;
    case (state_q)
      MULT, DIV, FIX: io.busy = 1'b1;
      DONE:           io.done = 1'b1;
      default: ;
    endcase
  end

  assign io.hi       = hi_q;
  assign io.lo       = lo_q;
  assign io.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero/latency,
// a negedge monitor pops on every done pulse. Unsigned vectors run when MULTDIV_UNSIGNED_EN is set.
module tb_mult_div_unit;
  import multdiv_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  mult_div_unit_if #(.WIDTH(MD_WIDTH)) io ();

  mult_div_unit #(.WIDTH(MD_WIDTH)) dut (
    .clock (clock),
    .reset (rst_n),
    .io    (io)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", {31'b0, io.done}, 32'd0);
      if (io.done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_hi"}, io.hi, mon_e.hi);
          chk({mon_e.name, "_lo"}, io.lo, mon_e.lo);
          chk({mon_e.name, "_dz"}, {31'b0, io.div_zero}, {31'b0, mon_e.dz});
          chk({mon_e.name, "_lat"}, cyc - mon_e.start_cyc + 1, mon_e.lat);
        end
      end
      prev_done = io.done;
    end
  end

  task automatic issue(input string name, input logic sm, input logic sd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int elat, input logic push);
    exp_t e;
    @(negedge clock);
    io.start_mult = sm;
    io.start_div  = sd;
    io.a          = a;
    io.b          = b;
    @(posedge clock);
    #1;
    io.start_mult = 1'b0;
    io.start_div  = 1'b0;
    e.hi        = ehi;
    e.lo        = elo;
    e.dz        = edz;
    e.lat       = elat;
    e.start_cyc = cyc;
    e.name      = name;
    if (push) sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int nd;
    io.start_mult = 1'b0;
    io.start_div  = 1'b0;
    io.a          = '0;
    io.b          = '0;
`ifdef MULTDIV_UNSIGNED_EN
    io.unsigned_op = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {31'b0, io.busy}, 32'd0);
    chk("rst_done", {31'b0, io.done}, 32'd0);
    chk("rst_dz", {31'b0, io.div_zero}, 32'd0);
    chk("rst_hi", io.hi, 32'd0);
    chk("rst_lo", io.lo, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    issue("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, 1);
    chk("mul_busy_rise", {31'b0, io.busy}, 32'd1);
    drain("mul_7_m3");

    issue("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 33, 1);
    drain("mul_min_min");

    issue("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, 1);
    chk("div_busy_rise", {31'b0, io.busy}, 32'd1);
    drain("div_m7_2");

    issue("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 34, 1);
    drain("div_7_m2");

    issue("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 34, 1);
    drain("div_ovf");

    issue("div_100_7", 0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, 1);
    drain("div_100_7");

    issue("div_zero", 0, 1, 32'd5, 32'd0, 32'd2, 32'd14, 1, 1, 1);
    chk("dz_no_busy", {31'b0, io.busy}, 32'd0);
    drain("div_zero");

    issue("mul_clr_dz", 1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, 33, 1);
    chk("dz_cleared", {31'b0, io.div_zero}, 32'd0);
    drain("mul_clr_dz");

    issue("collide", 1, 1, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 0, 33, 1);
    drain("collide");

    issue("div_while_busy", 1, 0, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFD3, 0, 33, 1);
    repeat (5) @(negedge clock);
    io.start_div = 1'b1;
    io.a         = 32'd9;
    io.b         = 32'd0;
    @(negedge clock);
    io.start_div = 1'b0;
    drain("div_while_busy");

    issue("abort", 1, 0, 32'd1234, 32'd5678, 32'd0, 32'd0, 0, 33, 0);
    repeat (9) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, io.busy}, 32'd0);
    chk("abort_done", {31'b0, io.done}, 32'd0);
    chk("abort_hi", io.hi, 32'd0);
    chk("abort_lo", io.lo, 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (io.done) nd++;
    end
    chk("abort_no_done", nd, 32'd0);

    issue("mul_after_abort", 1, 0, 32'd5, 32'd5, 32'd0, 32'd25, 0, 33, 1);
    drain("mul_after_abort");

`ifdef MULTDIV_UNSIGNED_EN
    io.unsigned_op = 1'b1;
    issue("mulu_ff_2", 1, 0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 0, 33, 1);
    drain("mulu_ff_2");
    issue("mulu_2_ff", 1, 0, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 0, 33, 1);
    drain("mulu_2_ff");
    issue("divu_ff_2", 0, 1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 0, 34, 1);
    drain("divu_ff_2");
    io.unsigned_op = 1'b0;
`endif

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
